// File: rtl/jm_pkg.sv
// Shared constants and types for the kernel dispatcher: descriptor field
// offsets, dispatch FSM states and the return code reported on a timeout.
package jm_pkg;
  localparam int PASID_LSB = 0;
  localparam int JOBID_LSB = 16;
  localparam int JOBID_W   = 16;

  localparam logic [255:0] RCODE_TIMEOUT = '1;

  typedef enum logic {IDLE, ISSUE} disp_state_e;
endpackage

// File: rtl/jm_kernel_dispatcher_if.sv
// Handshake bundle between the dispatcher, job_manager, the kernels and job_completion.
interface jm_kernel_dispatcher_if
  import jm_pkg::*;
#(
  parameter int HOST_DWIDTH = 1024,
  parameter int KERNEL_NUM  = 4,
  parameter int PASID_WIDTH = 9,
  parameter int RCODE_WIDTH = 16
);
  logic                                  dsc_ready_i;
  logic [HOST_DWIDTH-1:0]                dsc_data_i;
  logic                                  dsc_pull_o;
  logic [KERNEL_NUM-1:0]                 engine_start;
  logic [HOST_DWIDTH-1:0]                jd_payload;
  logic [KERNEL_NUM-1:0]                 engine_done;
  logic [KERNEL_NUM*RCODE_WIDTH-1:0]     return_code;
  logic                                  complete_ready_i;
  logic                                  complete_push_o;
  logic [RCODE_WIDTH+PASID_WIDTH+JOBID_W-1:0] return_data_o;
  logic [KERNEL_NUM-1:0]                 busy_o;
  logic                                  spurious_o;

  modport slave (
    input  dsc_ready_i, dsc_data_i, engine_done, return_code, complete_ready_i,
    output dsc_pull_o, engine_start, jd_payload, complete_push_o, return_data_o,
           busy_o, spurious_o
  );

  modport master (
    output dsc_ready_i, dsc_data_i, engine_done, return_code, complete_ready_i,
    input  dsc_pull_o, engine_start, jd_payload, complete_push_o, return_data_o,
           busy_o, spurious_o
  );
endinterface

// File: rtl/jm_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot grant plus index.
module jm_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jm_kernel_dispatcher.sv
// Issues job descriptors round-robin to KERNEL_NUM kernels and returns per-kernel
// completion records. Optional watchdog: define JM_DISPATCH_TIMEOUT_EN.
module jm_kernel_dispatcher
  import jm_pkg::*;
#(
  parameter int HOST_DWIDTH = 1024,
  parameter int KERNEL_NUM  = 4,
  parameter int PASID_WIDTH = 9,
  parameter int RCODE_WIDTH = 16,
  parameter int TIMEOUT_CYC = 2**20
) (
  input logic                   clk,
  input logic                   rst_n,
  jm_kernel_dispatcher_if.slave bus
);
  localparam int KW  = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int RDW = RCODE_WIDTH + PASID_WIDTH + JOBID_W;

  disp_state_e                           state_q, state_d;
  logic [KERNEL_NUM-1:0]                 sel_q, sel_d;
  logic [KW-1:0]                         dptr_q, dptr_d, cptr_q, cptr_d;
  logic [KERNEL_NUM-1:0]                 busy_q, busy_d, pend_q, pend_d;
  logic [KERNEL_NUM-1:0][RCODE_WIDTH-1:0] rcode_q, rcode_d;
  logic [KERNEL_NUM-1:0][PASID_WIDTH-1:0] pasid_q, pasid_d;
  logic [KERNEL_NUM-1:0][JOBID_W-1:0]    jobid_q, jobid_d;
  logic [HOST_DWIDTH-1:0]                jd_q, jd_d;
  logic                                  spur_q, spur_d, push_q, push_d;
  logic [RDW-1:0]                        ret_q, ret_d;
  logic                                  pull;
  logic [KERNEL_NUM-1:0]                 start, tmo_hit;
  logic [KERNEL_NUM-1:0]                 free_gnt, cmp_gnt;
  logic [KW-1:0]                         free_idx, cmp_idx;
  logic                                  free_any, cmp_any;

  function automatic logic [KW-1:0] ptr_inc(input logic [KW-1:0] i);
    return (i == KW'(KERNEL_NUM-1)) ? '0 : i + 1'b1;
  endfunction

  jm_rr_arbiter #(.N(KERNEL_NUM)) u_free_arb (
    .req(~busy_q), .ptr(dptr_q), .gnt(free_gnt), .idx(free_idx), .vld(free_any)
  );

  jm_rr_arbiter #(.N(KERNEL_NUM)) u_cmp_arb (
    .req(pend_q), .ptr(cptr_q), .gnt(cmp_gnt), .idx(cmp_idx), .vld(cmp_any)
  );

  assign start = (state_q == ISSUE) ? sel_q : '0;

`ifdef JM_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [KERNEL_NUM-1:0][CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counting only while the kernel owes a result; a captured done freezes it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = '0;
    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (start[k]) begin
        tmo_cnt_d[k] = '0;
      end else if (busy_q[k] && !pend_q[k]) begin
        tmo_cnt_d[k] = tmo_cnt_q[k] + 1'b1;
        tmo_hit[k]   = (tmo_cnt_q[k] == CW'(TIMEOUT_CYC - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = '0;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dptr_d  = dptr_q;
    cptr_d  = cptr_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    rcode_d = rcode_q;
    pasid_d = pasid_q;
    jobid_d = jobid_q;
    jd_d    = jd_q;
    spur_d  = spur_q;
    push_d  = 1'b0;
    ret_d   = ret_q;
    pull    = 1'b0;

    case (state_q)
      IDLE: if (bus.dsc_ready_i && free_any) begin
        pull             = 1'b1;
        state_d          = ISSUE;
        sel_d            = free_gnt;
        dptr_d           = ptr_inc(free_idx);
        jd_d             = bus.dsc_data_i;
        pasid_d[free_idx] = bus.dsc_data_i[PASID_LSB +: PASID_WIDTH];
        jobid_d[free_idx] = bus.dsc_data_i[JOBID_LSB +: JOBID_W];
      end
      ISSUE: begin
        busy_d  = busy_q | sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A real done in the same cycle as the watchdog firing keeps its own code.
    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (tmo_hit[k]) begin
        pend_d[k]  = 1'b1;
        rcode_d[k] = RCODE_WIDTH'(RCODE_TIMEOUT);
      end
      if (bus.engine_done[k]) begin
        if (busy_q[k] && !pend_q[k]) begin
          pend_d[k]  = 1'b1;
          rcode_d[k] = bus.return_code[k*RCODE_WIDTH +: RCODE_WIDTH];
        end else begin
          spur_d = 1'b1;
        end
      end
    end

    // push_q gating spaces records two cycles apart.
    if (cmp_any && bus.complete_ready_i && !push_q) begin
      push_d = 1'b1;
      ret_d  = {rcode_q[cmp_idx], pasid_q[cmp_idx], jobid_q[cmp_idx]};
      pend_d = pend_d & ~cmp_gnt;
      busy_d = busy_d & ~cmp_gnt;
      cptr_d = ptr_inc(cmp_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dptr_q  <= '0;
      cptr_q  <= '0;
      busy_q  <= '0;
      pend_q  <= '0;
      rcode_q <= '0;
      pasid_q <= '0;
      jobid_q <= '0;
      jd_q    <= '0;
      spur_q  <= 1'b0;
      push_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dptr_q  <= dptr_d;
      cptr_q  <= cptr_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      rcode_q <= rcode_d;
      pasid_q <= pasid_d;
      jobid_q <= jobid_d;
      jd_q    <= jd_d;
      spur_q  <= spur_d;
      push_q  <= push_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.dsc_pull_o      = pull;
  assign bus.engine_start    = start;
  assign bus.jd_payload      = jd_q;
  assign bus.complete_push_o = push_q;
  assign bus.return_data_o   = ret_q;
  assign bus.busy_o          = busy_q;
  assign bus.spurious_o      = spur_q;
endmodule

// File: tb/tb_jm_kernel_dispatcher.sv
// Bench for jm_kernel_dispatcher: descriptor table driven dispatch, scoreboard of completion records.
module tb_jm_kernel_dispatcher;
  localparam int HD = 1024, KN = 4, PW = 9, RW = 16, TMO = 64;
  localparam int RDW = RW + PW + 16;

  typedef struct {
    logic [PW-1:0] pasid;
    logic [15:0]   job;
    int            exp_k;
    logic [RW-1:0] rcode;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0, chks = 0, cyc = 0, n_push = 0;
  vec_t tbl [12];
  logic [RDW-1:0] sb [$];
  logic [RDW-1:0] sb_exp;
  int   push_cyc [$];
  int   pull_cyc [$];

  jm_kernel_dispatcher_if #(.HOST_DWIDTH(HD), .KERNEL_NUM(KN), .PASID_WIDTH(PW),
                            .RCODE_WIDTH(RW)) bus ();

  jm_kernel_dispatcher #(.HOST_DWIDTH(HD), .KERNEL_NUM(KN), .PASID_WIDTH(PW),
                         .RCODE_WIDTH(RW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every observed record must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.complete_push_o) begin
      push_cyc.push_back(cyc);
      n_push++;
      chks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL push_unexpected: got %0h, expected no record", bus.return_data_o);
      end else begin
        sb_exp = sb.pop_front();
        if (bus.return_data_o !== sb_exp) begin
          errs++;
          $display("FAIL return_data: got %0h, expected %0h", bus.return_data_o, sb_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [HD-1:0] mk_desc(input int i);
    logic [HD-1:0] d;
    d = '0;
    d[HD-1 -: 8]  = 8'hC3 ^ tbl[i].job[7:0];
    d[PW-1:0]     = tbl[i].pasid;
    d[31:16]      = tbl[i].job;
    return d;
  endfunction

  function automatic logic [RDW-1:0] rec(input int i, input logic [RW-1:0] code);
    return {code, tbl[i].pasid, tbl[i].job};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic dispatch(input int i);
    int b;
    bus.dsc_data_i  = mk_desc(i);
    bus.dsc_ready_i = 1'b1;
    b = 0;
    @(negedge clk);
    while (!bus.dsc_pull_o && b < 20) begin
      step(1);
      b++;
      @(negedge clk);
    end
    chk("dsc_pull", 64'(bus.dsc_pull_o), 64'd1);
    pull_cyc.push_back(cyc);
    step(1);
    bus.dsc_ready_i = 1'b0;
    @(negedge clk);
    chk("engine_start", 64'(bus.engine_start), 64'(1 << tbl[i].exp_k));
    step(1);
  endtask

  task automatic done_pulse(input logic [KN-1:0] mask, input int i0, input int i1,
                            input int i2, input int i3);
    int ids [4];
    ids = '{i0, i1, i2, i3};
    for (int k = 0; k < KN; k++)
      bus.return_code[k*RW +: RW] = (ids[k] >= 0) ? tbl[ids[k]].rcode : 16'h0BAD;
    bus.engine_done = mask;
    step(1);
    bus.engine_done = '0;
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int b;
    b = 0;
    while (n_push < n && b < budget) begin
      step(1);
      b++;
    end
    chk("push_count", 64'(n_push), 64'(n));
  endtask

  initial begin
    int t0, base;
    tbl[0]  = '{9'h011, 16'h1000, 0, 16'h0101};
    tbl[1]  = '{9'h022, 16'h2001, 1, 16'h0202};
    tbl[2]  = '{9'h005, 16'hBEEF, 2, 16'h1234};
    tbl[3]  = '{9'h1FF, 16'h4003, 3, 16'h0404};
    tbl[4]  = '{9'h100, 16'h5004, 0, 16'h0A0A};
    tbl[5]  = '{9'h0AA, 16'h6005, 1, 16'h1B1B};
    tbl[6]  = '{9'h155, 16'h7006, 2, 16'h2C2C};
    tbl[7]  = '{9'h001, 16'h8007, 3, 16'h3D3D};
    tbl[8]  = '{9'h033, 16'h9008, 0, 16'h7777};
    tbl[9]  = '{9'h044, 16'hA009, 1, 16'h8888};
    tbl[10] = '{9'h066, 16'hB00A, 2, 16'h9999};
    tbl[11] = '{9'h0F0, 16'hCAFE, 0, 16'h0000};

    bus.dsc_ready_i = 1'b0;
    bus.dsc_data_i = '0;
    bus.engine_done = '0;
    bus.return_code = '0;
    bus.complete_ready_i = 1'b1;
    step(2);
    @(negedge clk);
    chk("rst_pull", 64'(bus.dsc_pull_o), 64'd0);
    chk("rst_start", 64'(bus.engine_start), 64'd0);
    chk("rst_push", 64'(bus.complete_push_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_spurious", 64'(bus.spurious_o), 64'd0);
    chk("rst_jd_zero", 64'(bus.jd_payload == '0), 64'd1);
    rst_n = 1'b1;
    step(1);

    // Back-to-back descriptors fill kernels 0..3, then the fifth stalls.
    for (int i = 0; i < 4; i++) dispatch(i);
    for (int i = 1; i < 4; i++)
      chk("pull_spacing", 64'(pull_cyc[i] - pull_cyc[i-1]), 64'd2);
    chk("jd_payload", 64'(bus.jd_payload == mk_desc(3)), 64'd1);
    bus.dsc_data_i = mk_desc(4);
    bus.dsc_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("all_busy_no_pull", 64'(bus.dsc_pull_o), 64'd0);
      step(1);
    end
    bus.dsc_ready_i = 1'b0;
    chk("all_busy", 64'(bus.busy_o), 64'hF);

    // Kernel 2 completes: record two cycles later.
    sb.push_back(rec(2, tbl[2].rcode));
    bus.return_code[2*RW +: RW] = tbl[2].rcode;
    bus.engine_done = 4'b0100;
    @(negedge clk);
    chk("k2_push_t", 64'(bus.complete_push_o), 64'd0);
    step(1);
    bus.engine_done = '0;
    @(negedge clk);
    chk("k2_push_t1", 64'(bus.complete_push_o), 64'd0);
    step(1);
    @(negedge clk);
    chk("k2_push_t2", 64'(bus.complete_push_o), 64'd1);
    chk("k2_busy_clear", 64'(bus.busy_o), 64'hB);
    step(1);

    // Reset between done and push drops the job.
    base = n_push;
    done_pulse(4'b0001, 0, -1, -1, -1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("midjob_no_push", 64'(n_push), 64'(base));
    chk("midjob_busy", 64'(bus.busy_o), 64'd0);

    // All four done together: pushes k0..k3, two cycles apart.
    for (int i = 4; i < 8; i++) dispatch(i);
    for (int i = 4; i < 8; i++) sb.push_back(rec(i, tbl[i].rcode));
    base = push_cyc.size();
    t0 = cyc;
    done_pulse(4'b1111, 4, 5, 6, 7);
    wait_pushes(n_push + 4, 30);
    for (int i = 0; i < 4; i++)
      if (base + i < push_cyc.size())
        chk("push_cycle", 64'(push_cyc[base+i] - t0), 64'(2 + 2*i));
    chk("all_free", 64'(bus.busy_o), 64'd0);

    // Completion back-pressure while dispatch continues.
    bus.complete_ready_i = 1'b0;
    dispatch(8);
    dispatch(9);
    sb.push_back(rec(8, tbl[8].rcode));
    sb.push_back(rec(9, tbl[9].rcode));
    base = n_push;
    done_pulse(4'b0011, 8, 9, -1, -1);
    dispatch(10);
    step(95);
    chk("held_no_push", 64'(n_push), 64'(base));
    chk("held_busy", 64'(bus.busy_o), 64'h7);
    bus.complete_ready_i = 1'b1;
    wait_pushes(base + 2, 20);
    chk("after_release_busy", 64'(bus.busy_o), 64'h4);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Done on an idle kernel is flagged and sticky until reset.
    base = n_push;
    done_pulse(4'b0010, -1, 9, -1, -1);
    step(4);
    chk("spurious_set", 64'(bus.spurious_o), 64'd1);
    chk("spurious_no_push", 64'(n_push), 64'(base));
    do_reset();
    @(negedge clk);
    chk("spurious_reset", 64'(bus.spurious_o), 64'd0);
    step(1);

`ifdef JM_DISPATCH_TIMEOUT_EN
    // Kernel 0 never answers: watchdog retires it with all-ones code.
    sb.push_back(rec(11, 16'hFFFF));
    base = n_push;
    dispatch(11);
    wait_pushes(base + 1, 200);
    chk("tmo_busy_clear", 64'(bus.busy_o), 64'd0);
    done_pulse(4'b0001, 11, -1, -1, -1);
    step(2);
    chk("tmo_late_spurious", 64'(bus.spurious_o), 64'd1);
    chk("tmo_late_no_push", 64'(n_push), 64'(base + 1));
`endif

    step(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end
endmodule
